// File: rtl/fifo_multich.sv
// rtl/fifo_multich.sv - NUM_CH independent DEPTH x DATASIZE queues sharing one write and one read port.
// Status outputs are registered from next-state pointers; flush overrides any access to its channel.
module fifo_multich #(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 4,
    parameter int DATASIZE  = 30,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PW = AW + 1
) (
    input  logic                 fifo_clk,
    input  logic                 fifo_rst,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_ch,
    input  logic [DATASIZE-1:0]  wdata,
    input  logic                 rd_en,
    input  logic [CW-1:0]        rd_ch,
    output logic [DATASIZE-1:0]  rdata,
    output logic                 rvalid,
    input  logic [NUM_CH-1:0]    flush,
    output logic [NUM_CH-1:0]    full,
    output logic [NUM_CH-1:0]    empty_n,
    output logic [NUM_CH-1:0]    almost_full,
    output logic [NUM_CH*PW-1:0] count,
    output logic                 err_ovf,
    output logic                 err_udf
);

    localparam logic [CW:0] NUM_CH_W = NUM_CH[CW:0];

    logic [DATASIZE-1:0] mem [NUM_CH][DEPTH];
    logic [PW-1:0] wptr     [NUM_CH];
    logic [PW-1:0] rptr     [NUM_CH];
    logic [PW-1:0] wptr_nxt [NUM_CH];
    logic [PW-1:0] rptr_nxt [NUM_CH];
    logic [PW-1:0] cnt_nxt  [NUM_CH];

    logic                wr_ok, rd_ok;
    logic                wr_full, wr_flush, rd_ne, rd_flush;
    logic [PW-1:0]       wr_wptr, rd_rptr;
    logic [DATASIZE-1:0] rd_head;
    logic                wr_acc, rd_acc;

    // Out-of-range channels look full/empty so the matching error pulse fires.
    assign wr_ok = ({1'b0, wr_ch} < NUM_CH_W);
    assign rd_ok = ({1'b0, rd_ch} < NUM_CH_W);

    always_comb begin
        wr_full  = 1'b1;
        wr_flush = 1'b0;
        wr_wptr  = '0;
        rd_ne    = 1'b0;
        rd_flush = 1'b0;
        rd_rptr  = '0;
        rd_head  = '0;
        if (wr_ok) begin
            wr_full  = full[wr_ch];
            wr_flush = flush[wr_ch];
            wr_wptr  = wptr[wr_ch];
        end
        if (rd_ok) begin
            rd_ne    = empty_n[rd_ch];
            rd_flush = flush[rd_ch];
            rd_rptr  = rptr[rd_ch];
            rd_head  = mem[rd_ch][rd_rptr[AW-1:0]];
        end
    end

    assign wr_acc = wr_en && !wr_full && !wr_flush;
    assign rd_acc = rd_en && rd_ne && !rd_flush;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wptr_nxt[c] = wptr[c];
            rptr_nxt[c] = rptr[c];
            if (flush[c]) begin
                rptr_nxt[c] = wptr[c];
            end else begin
                if (wr_acc && (wr_ch == CW'(c))) wptr_nxt[c] = wptr[c] + PW'(1);
                if (rd_acc && (rd_ch == CW'(c))) rptr_nxt[c] = rptr[c] + PW'(1);
            end
            cnt_nxt[c] = wptr_nxt[c] - rptr_nxt[c];
        end
    end

    always_ff @(posedge fifo_clk) begin
        if (wr_acc) mem[wr_ch][wr_wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge fifo_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
            full        <= '0;
            empty_n     <= '0;
            almost_full <= '0;
            count       <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
            err_ovf     <= 1'b0;
            err_udf     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c]             <= wptr_nxt[c];
                rptr[c]             <= rptr_nxt[c];
                full[c]             <= (cnt_nxt[c] == PW'(DEPTH));
                empty_n[c]          <= (cnt_nxt[c] != '0);
                almost_full[c]      <= (cnt_nxt[c] >= PW'(AF_THRESH));
                count[c*PW +: PW]   <= cnt_nxt[c];
            end
            rvalid  <= rd_acc;
            if (rd_acc) rdata <= rd_head;
            err_ovf <= wr_en && wr_full && !wr_flush;
            err_udf <= rd_en && !rd_ne && !rd_flush;
        end
    end

endmodule

// File: tb/tb_fifo_multich.sv
// tb/tb_fifo_multich.sv - directed table-driven bench for fifo_multich.
module tb_fifo_multich;

    logic        fifo_clk = 1'b0;
    logic        fifo_rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [29:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_ch = '0;
    logic [29:0] rdata;
    logic        rvalid;
    logic [3:0]  flush = '0;
    logic [3:0]  full, empty_n, almost_full;
    logic [11:0] count;
    logic        err_ovf, err_udf;

    int total = 0;
    int passed = 0;

    fifo_multich #(.NUM_CH(4), .DEPTH(4), .DATASIZE(30), .AF_THRESH(3)) dut (
        .fifo_clk(fifo_clk), .fifo_rst(fifo_rst),
        .wr_en(wr_en), .wr_ch(wr_ch), .wdata(wdata),
        .rd_en(rd_en), .rd_ch(rd_ch), .rdata(rdata), .rvalid(rvalid),
        .flush(flush), .full(full), .empty_n(empty_n), .almost_full(almost_full),
        .count(count), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 fifo_clk = ~fifo_clk;

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_ch;
        logic [29:0] wdata;
        logic        rd_en;
        logic [1:0]  rd_ch;
        logic [3:0]  flush;
        logic        rvalid;
        logic [29:0] rdata;
        logic [3:0]  full;
        logic [3:0]  en;
        logic [3:0]  af;
        logic [11:0] count;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vt[16];

    function automatic logic [11:0] cnt(input int c3, input int c2, input int c1, input int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    function automatic vec_t mk(input logic we, input logic [1:0] wc, input logic [29:0] wd,
                                input logic re, input logic [1:0] rc, input logic [3:0] fl,
                                input logic rv, input logic [29:0] rd, input logic [3:0] fu,
                                input logic [3:0] en, input logic [3:0] af, input logic [11:0] ct,
                                input logic ov, input logic ud);
        vec_t v;
        v.wr_en = we; v.wr_ch = wc; v.wdata = wd; v.rd_en = re; v.rd_ch = rc; v.flush = fl;
        v.rvalid = rv; v.rdata = rd; v.full = fu; v.en = en; v.af = af; v.count = ct;
        v.ovf = ov; v.udf = ud;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic e_rv, input logic [29:0] e_rd,
                           input logic [3:0] e_full, input logic [3:0] e_en, input logic [3:0] e_af,
                           input logic [11:0] e_cnt, input logic e_ovf, input logic e_udf);
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(e_rv));
        chk({tag, ".rdata"}, 32'(rdata), 32'(e_rd));
        chk({tag, ".full"}, 32'(full), 32'(e_full));
        chk({tag, ".empty_n"}, 32'(empty_n), 32'(e_en));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(e_af));
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".err_ovf"}, 32'(err_ovf), 32'(e_ovf));
        chk({tag, ".err_udf"}, 32'(err_udf), 32'(e_udf));
    endtask

    // Drive one cycle of inputs after a falling edge, then sample just past the rising edge.
    task automatic apply(input logic we, input logic [1:0] wc, input logic [29:0] wd,
                         input logic re, input logic [1:0] rc, input logic [3:0] fl);
        @(negedge fifo_clk);
        wr_en = we; wr_ch = wc; wdata = wd; rd_en = re; rd_ch = rc; flush = fl;
        @(posedge fifo_clk);
        #1;
    endtask

    initial begin
        //        we  wc   wdata         re  rc   flush    rv  rdata         full     en       af       count          ovf udf
        vt[0]  = mk(1, 2'd2, 30'h1,        0, 2'd0, 4'h0,   0, 30'h0,        4'h0,    4'h4,    4'h0,    cnt(0,1,0,0),  0, 0);
        vt[1]  = mk(1, 2'd2, 30'h2,        0, 2'd0, 4'h0,   0, 30'h0,        4'h0,    4'h4,    4'h0,    cnt(0,2,0,0),  0, 0);
        vt[2]  = mk(1, 2'd2, 30'h3,        0, 2'd0, 4'h0,   0, 30'h0,        4'h0,    4'h4,    4'h4,    cnt(0,3,0,0),  0, 0);
        vt[3]  = mk(1, 2'd2, 30'h4,        0, 2'd0, 4'h0,   0, 30'h0,        4'h4,    4'h4,    4'h4,    cnt(0,4,0,0),  0, 0);
        vt[4]  = mk(1, 2'd2, 30'h5,        0, 2'd0, 4'h0,   0, 30'h0,        4'h4,    4'h4,    4'h4,    cnt(0,4,0,0),  1, 0);
        vt[5]  = mk(0, 2'd0, 30'h0,        1, 2'd2, 4'h0,   1, 30'h1,        4'h0,    4'h4,    4'h4,    cnt(0,3,0,0),  0, 0);
        vt[6]  = mk(0, 2'd0, 30'h0,        1, 2'd2, 4'h0,   1, 30'h2,        4'h0,    4'h4,    4'h0,    cnt(0,2,0,0),  0, 0);
        vt[7]  = mk(0, 2'd0, 30'h0,        1, 2'd2, 4'h0,   1, 30'h3,        4'h0,    4'h4,    4'h0,    cnt(0,1,0,0),  0, 0);
        vt[8]  = mk(0, 2'd0, 30'h0,        1, 2'd2, 4'h0,   1, 30'h4,        4'h0,    4'h0,    4'h0,    cnt(0,0,0,0),  0, 0);
        vt[9]  = mk(0, 2'd0, 30'h0,        1, 2'd0, 4'h0,   0, 30'h4,        4'h0,    4'h0,    4'h0,    cnt(0,0,0,0),  0, 1);
        vt[10] = mk(1, 2'd1, 30'h11,       0, 2'd0, 4'h0,   0, 30'h4,        4'h0,    4'h2,    4'h0,    cnt(0,0,1,0),  0, 0);
        vt[11] = mk(1, 2'd0, 30'hA,        1, 2'd1, 4'h0,   1, 30'h11,       4'h0,    4'h1,    4'h0,    cnt(0,0,0,1),  0, 0);
        vt[12] = mk(1, 2'd0, 30'hB,        1, 2'd0, 4'h0,   1, 30'hA,        4'h0,    4'h1,    4'h0,    cnt(0,0,0,1),  0, 0);
        vt[13] = mk(0, 2'd0, 30'h0,        1, 2'd0, 4'h0,   1, 30'hB,        4'h0,    4'h0,    4'h0,    cnt(0,0,0,0),  0, 0);
        vt[14] = mk(1, 2'd2, 30'h3FFFFFFF, 1, 2'd2, 4'h0,   0, 30'hB,        4'h0,    4'h4,    4'h0,    cnt(0,1,0,0),  0, 1);
        vt[15] = mk(0, 2'd0, 30'h0,        1, 2'd2, 4'h0,   1, 30'h3FFFFFFF, 4'h0,    4'h0,    4'h0,    cnt(0,0,0,0),  0, 0);

        @(negedge fifo_clk);
        chk_all("reset", 0, 30'h0, 4'h0, 4'h0, 4'h0, 12'h0, 0, 0);
        @(negedge fifo_clk);
        fifo_rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vt[i].wr_en, vt[i].wr_ch, vt[i].wdata, vt[i].rd_en, vt[i].rd_ch, vt[i].flush);
            chk_all($sformatf("vec%0d", i), vt[i].rvalid, vt[i].rdata, vt[i].full, vt[i].en,
                    vt[i].af, vt[i].count, vt[i].ovf, vt[i].udf);
        end

        // Steady write+read on ch1 at count 2 across several pointer wraps.
        apply(1, 2'd1, 30'h21, 0, 2'd0, 4'h0);
        apply(1, 2'd1, 30'h22, 0, 2'd0, 4'h0);
        chk("ch1_prefill.count", 32'(count), 32'(cnt(0,0,2,0)));
        for (int i = 0; i < 10; i++) begin
            apply(1, 2'd1, 30'(32'h23 + i), 1, 2'd1, 4'h0);
            chk($sformatf("wrap%0d.rdata", i), 32'(rdata), 32'h21 + 32'(i));
            chk($sformatf("wrap%0d.rvalid", i), 32'(rvalid), 32'd1);
            chk($sformatf("wrap%0d.count", i), 32'(count), 32'(cnt(0,0,2,0)));
            chk($sformatf("wrap%0d.empty_n", i), 32'(empty_n), 32'h2);
        end

        // Flush of ch3 wins over a simultaneous write and read.
        apply(1, 2'd3, 30'h31, 0, 2'd0, 4'h0);
        apply(1, 2'd3, 30'h32, 0, 2'd0, 4'h0);
        apply(1, 2'd3, 30'h33, 0, 2'd0, 4'h0);
        chk_all("ch3_fill", 1'b0, 30'h2A, 4'h0, 4'hA, 4'h8, cnt(3,0,2,0), 0, 0);
        apply(1, 2'd3, 30'h99, 1, 2'd3, 4'h8);
        chk_all("ch3_flush", 1'b0, 30'h2A, 4'h0, 4'h2, 4'h0, cnt(0,0,2,0), 0, 0);
        apply(1, 2'd3, 30'h55, 0, 2'd0, 4'h0);
        apply(0, 2'd0, 30'h0, 1, 2'd3, 4'h0);
        chk_all("ch3_after", 1'b1, 30'h55, 4'h0, 4'h2, 4'h0, cnt(0,0,2,0), 0, 0);

        // Flushing a full channel suppresses the overflow pulse of a same-cycle write.
        for (int i = 0; i < 4; i++) apply(1, 2'd0, 30'(32'h41 + i), 0, 2'd0, 4'h0);
        chk("ch0_full.full", 32'(full), 32'h1);
        apply(1, 2'd0, 30'h45, 0, 2'd0, 4'h1);
        chk_all("ch0_flushfull", 1'b0, 30'h55, 4'h0, 4'h2, 4'h0, cnt(0,0,2,0), 0, 0);

        // Asynchronous reset between edges in the middle of a burst.
        apply(1, 2'd0, 30'h61, 0, 2'd0, 4'h0);
        @(negedge fifo_clk);
        wr_en = 1'b1; wr_ch = 2'd0; wdata = 30'h62; rd_en = 1'b1; rd_ch = 2'd1;
        @(posedge fifo_clk);
        #1;
        chk("pre_rst.rvalid", 32'(rvalid), 32'd1);
        #1;
        fifo_rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 30'h0, 4'h0, 4'h0, 4'h0, 12'h0, 0, 0);
        @(negedge fifo_clk);
        wr_en = 1'b0; rd_en = 1'b0;
        fifo_rst = 1'b0;
        apply(1, 2'd1, 30'h77, 0, 2'd0, 4'h0);
        chk_all("post_rst_wr", 0, 30'h0, 4'h0, 4'h2, 4'h0, cnt(0,0,1,0), 0, 0);
        apply(0, 2'd0, 30'h0, 1, 2'd1, 4'h0);
        chk_all("post_rst_rd", 1, 30'h77, 4'h0, 4'h0, 4'h0, 12'h0, 0, 0);
        apply(0, 2'd0, 30'h0, 0, 2'd0, 4'h0);
        chk("idle.rvalid", 32'(rvalid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
